// File: rtl/ray_arbiter_pkg.sv
// Shared ray-tracer types: requester ids, select codes and the tag record that
// travels alongside each job through the intersection engine.
package ray_arbiter_pkg;

  // Requester identity; doubles as the round-robin pointer value.
  typedef enum logic {
    PORT_PRIMARY = 1'b0,
    PORT_SHADOW  = 1'b1
  } port_e;

  // Primary rays test against every object class.
  localparam logic [1:0] SELECT_ALL = 2'b11;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;

  // Per-job bookkeeping needed to route the result back to its requester.
  typedef struct packed {
    port_e               port;
    logic [HCOUNT_W-1:0] hcount;
    logic [VCOUNT_W-1:0] vcount;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/ray_arbiter_tag_fifo.sv
// In-order tag FIFO: synchronous, first-word-fall-through read, power-of-2
// depth with an extra pointer bit to tell full from empty.
module tag_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; both pointers wrap naturally through the extra MSB.
  always_ff @(posedge aclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge aclk) begin
    // NOTE: the array is deliberately not reset; the pointers alone define
    // which entries are valid, and this keeps it mappable to RAM.
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ray_arbiter.sv
// Two-port round-robin arbiter feeding the intersection engine, with an
// in-order tag FIFO that routes each engine result back to its requester.
module ray_arbiter
  import ray_arbiter_pkg::*;
#(
  parameter int         SIZE            = 32,
  parameter int         MAX_OUTSTANDING = 16,
  parameter logic [1:0] SHADOW_SELECT   = 2'b01
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  // primary-ray requester (port 0)
  input  logic [3*SIZE-1:0]                 p_ray_tdata,
  input  logic [10:0]                       p_hcount,
  input  logic [9:0]                        p_vcount,
  input  logic                              p_tvalid,
  output logic                              p_tready,
  // shadow-ray requester (port 1)
  input  logic [3*SIZE-1:0]                 s_ray_tdata,
  input  logic [10:0]                       s_hcount,
  input  logic [9:0]                        s_vcount,
  input  logic                              s_tvalid,
  output logic                              s_tready,
  // job to intersection engine
  output logic [3*SIZE-1:0]                 m_ray_tdata,
  output logic [1:0]                        m_select_objs,
  output logic [10:0]                       m_hcount,
  output logic [9:0]                        m_vcount,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  // engine result
  input  logic                              r_valid,
  input  logic [3*SIZE-1:0]                 r_hit_point,
  input  logic [3*SIZE-1:0]                 r_normal,
  input  logic                              r_hit_cylinder,
  input  logic                              r_hit_sphere,
  // routed result
  output logic                              o0_valid,
  output logic                              o1_valid,
  output logic [3*SIZE-1:0]                 o_hit_point,
  output logic [3*SIZE-1:0]                 o_normal,
  output logic                              o_hit_cylinder,
  output logic                              o_hit_sphere,
  output logic [10:0]                       o_hcount,
  output logic [9:0]                        o_vcount,
  // status
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
  output logic                              tag_error
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  port_e grant;
  port_e last_grant;
  port_e lock_port;
  logic  locked;
  logic  req_valid;
  logic  issue;
  logic  ret;
  logic  fifo_full;
  logic  fifo_empty;
  tag_t  push_tag;
  logic [TAG_W-1:0] pop_bits;
  tag_t  pop_tag;

  // Grant selection: hold a stalled grant, otherwise alternate when both ask.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    grant = PORT_PRIMARY;
    if (locked)
      grant = lock_port;
    else if (p_tvalid && s_tvalid)
      grant = (last_grant == PORT_PRIMARY) ? PORT_SHADOW : PORT_PRIMARY;
    else if (s_tvalid)
      grant = PORT_SHADOW;
  end

  // Job mux toward the engine; the FIFO fills exactly when outstanding
  // reaches MAX_OUTSTANDING, so its full flag is the issue-slot gate.
  always_comb begin
    req_valid     = (grant == PORT_PRIMARY) ? p_tvalid : s_tvalid;
    m_tvalid      = aresetn && req_valid && !fifo_full;
    issue         = m_tvalid && m_tready;
    p_tready      = issue && (grant == PORT_PRIMARY);
    s_tready      = issue && (grant == PORT_SHADOW);
    m_ray_tdata   = (grant == PORT_PRIMARY) ? p_ray_tdata : s_ray_tdata;
    m_hcount      = (grant == PORT_PRIMARY) ? p_hcount    : s_hcount;
    m_vcount      = (grant == PORT_PRIMARY) ? p_vcount    : s_vcount;
    m_select_objs = (grant == PORT_PRIMARY) ? SELECT_ALL  : SHADOW_SELECT;
  end

  // Round-robin pointer and stall lock.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      last_grant <= PORT_SHADOW;
      lock_port  <= PORT_PRIMARY;
      locked     <= 1'b0;
    end else begin
      locked    <= m_tvalid && !m_tready;
      lock_port <= grant;
      if (issue)
        last_grant <= grant;
    end
  end

  assign push_tag = '{port: grant, hcount: m_hcount, vcount: m_vcount};
  assign ret      = r_valid && !fifo_empty;
  assign pop_tag  = tag_t'(pop_bits);

  tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (issue),
    .push_data (push_tag),
    .pop       (ret),
    .pop_data  (pop_bits),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // In-flight count and sticky underflow flag.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      outstanding <= '0;
      tag_error   <= 1'b0;
    end else begin
      case ({issue, ret})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      if (r_valid && fifo_empty)
        tag_error <= 1'b1;
    end
  end

  // Result register: one-cycle strobe to the owning port, data held between.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      o0_valid       <= 1'b0;
      o1_valid       <= 1'b0;
      o_hit_point    <= '0;
      o_normal       <= '0;
      o_hit_cylinder <= 1'b0;
      o_hit_sphere   <= 1'b0;
      o_hcount       <= '0;
      o_vcount       <= '0;
    end else begin
      o0_valid <= ret && (pop_tag.port == PORT_PRIMARY);
      o1_valid <= ret && (pop_tag.port == PORT_SHADOW);
      if (ret) begin
        o_hit_point    <= r_hit_point;
        o_normal       <= r_normal;
        o_hit_cylinder <= r_hit_cylinder;
        o_hit_sphere   <= r_hit_sphere;
        o_hcount       <= pop_tag.hcount;
        o_vcount       <= pop_tag.vcount;
      end
    end
  end

endmodule

// File: tb/tb_ray_arbiter.sv
// Self-checking bench for ray_arbiter: directed scenarios plus randomized
// traffic compared cycle by cycle against a queue-based reference model.
module tb_ray_arbiter;

  localparam int SIZE = 32;
  localparam int MAXO = 16;
  localparam int W3   = 3 * SIZE;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [W3-1:0] p_ray_tdata, s_ray_tdata;
  logic [10:0]   p_hcount, s_hcount;
  logic [9:0]    p_vcount, s_vcount;
  logic          p_tvalid, s_tvalid, p_tready, s_tready;
  logic [W3-1:0] m_ray_tdata;
  logic [1:0]    m_select_objs;
  logic [10:0]   m_hcount;
  logic [9:0]    m_vcount;
  logic          m_tvalid, m_tready;
  logic          r_valid, r_hit_cylinder, r_hit_sphere;
  logic [W3-1:0] r_hit_point, r_normal;
  logic          o0_valid, o1_valid, o_hit_cylinder, o_hit_sphere;
  logic [W3-1:0] o_hit_point, o_normal;
  logic [10:0]   o_hcount;
  logic [9:0]    o_vcount;
  logic [4:0]    outstanding;
  logic          tag_error;

  ray_arbiter #(.SIZE(SIZE), .MAX_OUTSTANDING(MAXO), .SHADOW_SELECT(2'b01)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .p_ray_tdata(p_ray_tdata), .p_hcount(p_hcount), .p_vcount(p_vcount),
    .p_tvalid(p_tvalid), .p_tready(p_tready),
    .s_ray_tdata(s_ray_tdata), .s_hcount(s_hcount), .s_vcount(s_vcount),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_ray_tdata(m_ray_tdata), .m_select_objs(m_select_objs),
    .m_hcount(m_hcount), .m_vcount(m_vcount),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .r_valid(r_valid), .r_hit_point(r_hit_point), .r_normal(r_normal),
    .r_hit_cylinder(r_hit_cylinder), .r_hit_sphere(r_hit_sphere),
    .o0_valid(o0_valid), .o1_valid(o1_valid),
    .o_hit_point(o_hit_point), .o_normal(o_normal),
    .o_hit_cylinder(o_hit_cylinder), .o_hit_sphere(o_hit_sphere),
    .o_hcount(o_hcount), .o_vcount(o_vcount),
    .outstanding(outstanding), .tag_error(tag_error)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [W3-1:0] got, input logic [W3-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int port;
    int h;
    int v;
  } job_t;

  job_t m_q[$];          // jobs in flight, oldest first
  int   m_last;          // port granted most recently
  bit   m_stalled;       // previous cycle offered a job that was not taken
  int   m_stall_port;
  bit   m_err;
  int   pairs;           // cycles with both an issue and a return

  task automatic model_reset();
    m_q.delete();
    m_last = 1;
    m_stalled = 0;
    m_stall_port = 0;
    m_err = 0;
  endtask

  // Requesters hold their request stable until accepted.
  task automatic req_p(input int h, input int v);
    p_tvalid = 1'b1;
    p_hcount = 11'(h);
    p_vcount = 10'(v);
    p_ray_tdata = {$urandom, $urandom, $urandom};
  endtask

  task automatic req_s(input int h, input int v);
    s_tvalid = 1'b1;
    s_hcount = 11'(h);
    s_vcount = 10'(v);
    s_ray_tdata = {$urandom, $urandom, $urandom};
  endtask

  // One clock: called just after a rising edge.
  task automatic do_cycle(input bit rdy, input bit rv);
    int   g;
    bit   exp_mv, issue, ret;
    job_t j;
    logic [W3-1:0] hp, nm;
    bit   hc, hs;

    m_tready = rdy;
    r_valid  = rv;
    hp = {$urandom, $urandom, $urandom};
    nm = {$urandom, $urandom, $urandom};
    hc = 1'($urandom);
    hs = 1'($urandom);
    r_hit_point = hp; r_normal = nm; r_hit_cylinder = hc; r_hit_sphere = hs;
    #2;

    if (m_stalled)                  g = m_stall_port;
    else if (p_tvalid && s_tvalid)  g = 1 - m_last;
    else if (s_tvalid)              g = 1;
    else                            g = 0;
    exp_mv = (p_tvalid || s_tvalid) && (m_q.size() < MAXO);

    check("m_tvalid", W3'(m_tvalid), W3'(exp_mv));
    check("p_tready", W3'(p_tready), W3'(exp_mv && rdy && g == 0));
    check("s_tready", W3'(s_tready), W3'(exp_mv && rdy && g == 1));
    if (exp_mv) begin
      check("m_select_objs", W3'(m_select_objs), W3'(g == 0 ? 2'b11 : 2'b01));
      check("m_ray_tdata", m_ray_tdata, g == 0 ? p_ray_tdata : s_ray_tdata);
      check("m_hcount", W3'(m_hcount), W3'(g == 0 ? p_hcount : s_hcount));
      check("m_vcount", W3'(m_vcount), W3'(g == 0 ? p_vcount : s_vcount));
    end

    issue = exp_mv && rdy;
    ret   = rv && (m_q.size() > 0);
    if (rv && m_q.size() == 0) m_err = 1;
    if (issue && ret) pairs++;
    if (ret) j = m_q.pop_front();
    if (issue) m_q.push_back('{port: g,
                               h: int'(g == 0 ? p_hcount : s_hcount),
                               v: int'(g == 0 ? p_vcount : s_vcount)});
    m_stalled    = exp_mv && !rdy;
    m_stall_port = g;
    if (issue) m_last = g;

    @(posedge aclk);
    #1;
    if (issue && g == 0) p_tvalid = 1'b0;
    if (issue && g == 1) s_tvalid = 1'b0;
    r_valid = 1'b0;

    check("o0_valid", W3'(o0_valid), W3'(ret && j.port == 0));
    check("o1_valid", W3'(o1_valid), W3'(ret && j.port == 1));
    if (ret) begin
      check("o_hcount", W3'(o_hcount), W3'(j.h));
      check("o_vcount", W3'(o_vcount), W3'(j.v));
      check("o_hit_point", o_hit_point, hp);
      check("o_normal", o_normal, nm);
      check("o_hit_flags", W3'({o_hit_cylinder, o_hit_sphere}), W3'({hc, hs}));
    end
    check("outstanding", W3'(outstanding), W3'(m_q.size()));
    check("tag_error", W3'(tag_error), W3'(m_err));
  endtask

  task automatic apply_reset();
    aresetn = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      check("rst_m_tvalid", W3'(m_tvalid), '0);
      check("rst_p_tready", W3'(p_tready), '0);
      check("rst_s_tready", W3'(s_tready), '0);
      @(posedge aclk);
      #1;
    end
    aresetn = 1'b1;
    model_reset();
    check("rst_outstanding", W3'(outstanding), '0);
    check("rst_o_valid", W3'({o0_valid, o1_valid}), '0);
    check("rst_tag_error", W3'(tag_error), '0);
    check("rst_o_hit_point", o_hit_point, '0);
    check("rst_o_hcount", W3'(o_hcount), '0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && m_q.size() > 0; i++) do_cycle(1'b0, 1'b1);
    check("drained", W3'(outstanding), '0);
  endtask

  initial begin
    aresetn = 1'b0;
    p_tvalid = 1'b0; s_tvalid = 1'b0;
    p_ray_tdata = '0; s_ray_tdata = '0;
    p_hcount = '0; p_vcount = '0; s_hcount = '0; s_vcount = '0;
    m_tready = 1'b0; r_valid = 1'b0;
    r_hit_point = '0; r_normal = '0; r_hit_cylinder = 1'b0; r_hit_sphere = 1'b0;
    pairs = 0;
    model_reset();
    @(posedge aclk);
    #1;
    req_p(3, 3);
    req_s(4, 4);
    apply_reset();

    // Both ports always asking, engine always ready: grants alternate 0,1,...
    for (int i = 0; i < 6; i++) begin
      check("rr_grant_sel", W3'(m_select_objs), W3'(i % 2 == 0 ? 2'b11 : 2'b01));
      do_cycle(1'b1, 1'b0);
      if (!p_tvalid) req_p(10 + i, 20 + i);
      if (!s_tvalid) req_s(30 + i, 40 + i);
    end
    drain();

    // Engine stalls five cycles with both requesters waiting.
    for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b0);
    do_cycle(1'b1, 1'b0);
    do_cycle(1'b1, 1'b0);
    drain();

    // Ordered routing of three jobs.
    req_p(5, 7);
    do_cycle(1'b1, 1'b0);
    req_s(9, 2);
    do_cycle(1'b1, 1'b0);
    req_p(1, 1);
    do_cycle(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b1);

    // Fill to the limit, then a same-cycle return frees exactly one slot.
    for (int i = 0; i < MAXO; i++) begin
      if (i % 2 == 0) req_p(100 + i, i); else req_s(200 + i, i);
      do_cycle(1'b1, 1'b0);
    end
    check("full_outstanding", W3'(outstanding), W3'(MAXO));
    req_p(77, 66);
    do_cycle(1'b1, 1'b0);
    do_cycle(1'b1, 1'b1);
    do_cycle(1'b1, 1'b0);
    check("refill_issued", W3'(p_tvalid), '0);
    drain();

    // Randomized traffic with frequent simultaneous issue and return.
    for (int i = 0; i < 500; i++) begin
      if (!p_tvalid && $urandom_range(0, 2) != 0) req_p($urandom_range(0, 2047), $urandom_range(0, 1023));
      if (!s_tvalid && $urandom_range(0, 2) != 0) req_s($urandom_range(0, 2047), $urandom_range(0, 1023));
      do_cycle($urandom_range(0, 3) != 0, (m_q.size() > 0) && ($urandom_range(0, 1) == 1));
    end
    if (pairs < 40) check("pair_count", W3'(pairs), W3'(40));
    drain();

    // Reset with jobs in flight discards tags; a late result flags an error.
    req_p(8, 8);
    do_cycle(1'b1, 1'b0);
    p_tvalid = 1'b0; s_tvalid = 1'b0;
    apply_reset();
    do_cycle(1'b0, 1'b1);
    do_cycle(1'b0, 1'b0);
    do_cycle(1'b0, 1'b0);
    check("tag_error_held", W3'(tag_error), W3'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ray_arbiter.md
RAY_ARBITER -- requirements
Module: ray_arbiter

Interface
REQ-001 SHALL have parameter SIZE, default 32, float word width.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 16, in-flight job limit (power of 2, 2..64).
REQ-003 SHALL have parameter SHADOW_SELECT, default 2'b01, select_objs value for shadow rays.
REQ-004 aclk input 1 clock; aresetn input 1 synchronous active-low reset.
REQ-005 p_ray_tdata in 3*SIZE, p_hcount in 11, p_vcount in 10, p_tvalid in 1, p_tready out 1: primary-ray requester (port 0).
REQ-006 s_ray_tdata in 3*SIZE, s_hcount in 11, s_vcount in 10, s_tvalid in 1, s_tready out 1: shadow-ray requester (port 1).
REQ-007 m_ray_tdata out 3*SIZE, m_select_objs out 2, m_hcount out 11, m_vcount out 10, m_tvalid out 1, m_tready in 1: job to intersection engine.
REQ-008 r_valid in 1, r_hit_point in 3*SIZE, r_normal in 3*SIZE, r_hit_cylinder in 1, r_hit_sphere in 1: engine result, no backpressure.
REQ-009 o0_valid/o1_valid out 1 each, o_hit_point out 3*SIZE, o_normal out 3*SIZE, o_hit_cylinder out 1, o_hit_sphere out 1, o_hcount out 11, o_vcount out 10: routed result.
REQ-010 outstanding out clog2(MAX_OUTSTANDING)+1 in-flight count; tag_error out 1 sticky underflow flag.

Function
REQ-011 SHALL arbitrate round-robin: on a free issue slot, grant the requester not granted last when both valid; single valid requester wins.
REQ-012 SHALL lock grant while m_tvalid=1 and m_tready=0; m_* payload stable until handshake.
REQ-013 m_* SHALL be a combinational mux of the granted requester; m_select_objs = 2'b11 for port 0, SHADOW_SELECT for port 1.
REQ-014 m_tvalid SHALL be 0 when outstanding==MAX_OUTSTANDING; granted p_tready/s_tready = m_tready when issuing, else 0.
REQ-015 Each handshake (m_tvalid&m_tready) SHALL push a tag record {port id, hcount, vcount} into an in-order tag FIFO, depth MAX_OUTSTANDING.
REQ-016 Each r_valid SHALL pop one tag; result registered: o<id>_valid=1 for exactly one cycle, 1 cycle after r_valid, with o_* data = r_* and o_hcount/o_vcount from tag.
REQ-017 outstanding: +1 on issue only, -1 on return only, unchanged when both same cycle.
REQ-018 Issue and return in same cycle at outstanding==MAX_OUTSTANDING: issue blocked (REQ-014 uses current count); return proceeds.
REQ-019 r_valid with FIFO empty: no pop, no o*_valid, tag_error set until reset.
REQ-020 Tag FIFO pointers SHALL wrap modulo MAX_OUTSTANDING with no data loss across wrap.
REQ-021 Latency: request to m_tvalid 0 cycles combinational; r_valid to o*_valid 1 cycle.

Reset
REQ-022 On aresetn=0 at aclk edge: outstanding=0, FIFO empty, round-robin pointer favors port 0, o0_valid=o1_valid=0, tag_error=0, o_* data=0.
REQ-023 Reset mid-operation SHALL discard all in-flight tags; results arriving after reset with empty FIFO SHALL raise tag_error.
REQ-024 During reset p_tready=s_tready=m_tvalid=0.

Structure
REQ-025 SHALL place the port-id enum (PORT_PRIMARY=0, PORT_SHADOW=1), SELECT_ALL=2'b11 and the tag record struct in the shared ray-tracer package.
REQ-026 SHALL instantiate one sub-module, tag_fifo (synchronous, parameterized width/depth, full/empty flags); arbitration and counters inline.

Verification
REQ-027 Both ports valid continuously, m_tready=1: grants alternate 0,1,0,1; m_select_objs alternates 11,01.
REQ-028 m_tready=0 for 5 cycles with both valid: grant and m_* payload unchanged, no tready asserted.
REQ-029 Issue 16 jobs with no returns: outstanding=16, m_tvalid=0; one r_valid then frees one slot, next issue next cycle.
REQ-030 Issue p(h=5,v=7), s(h=9,v=2), p(h=1,v=1); return three results: o0_valid(5,7), o1_valid(9,2), o0_valid(1,1) in order, each one cycle after r_valid.
REQ-031 Run 40 issue/return pairs with simultaneous issue/return cycles: outstanding never drifts, tags correct across pointer wrap.
REQ-032 r_valid after reset with no issue: no o*_valid, tag_error=1 and held.
